seq_trojan_net_tap: RTL and testbench

Parametrised sequential Trojan insertion cell for the benchmark-pattern library. It sits in series on a W-bit bundle of internal nets inside a combinational benchmark netlist and passes them through unchanged while dormant. It counts rising edges of a rare-node trigger pattern. After THRESH edges it applies a selectable payload (invert, stuck-at-1, stuck-at-0, observe-only) to the masked nets for HOLD cycles, or indefinitely when HOLD is 0. It generalises the single-node, always-on combinational Trojan to a counter-triggered, time-limited, multi-net, multi-mode payload for detection-algorithm evaluation.

---
 rtl/seq_trojan_net_tap.sv | 140 ++++++++++++++
 tb/tb_seq_trojan_net_tap.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_trojan_net_tap.sv
// seq_trojan_net_tap: series tap on a W-bit net bundle. It passes the nets
// through while dormant. It counts rising edges of a rare trigger pattern,
// and after THRESH edges it corrupts the masked nets for HOLD cycles. When
// HOLD is 0 the corruption stays latched until clr, en=0 or reset.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// DISARMED | en low; counters held at 0, nets pass through
// ARMED    | counting trigger edges toward THRESH, nets pass through
// ACTIVE   | payload applied to masked nets, count saturated at THRESH
module seq_trojan_net_tap #(
  parameter int                 W        = 8,
  parameter int                 TRIG_W   = 4,
  parameter logic [TRIG_W-1:0]  TRIG_VAL = 4'hA,
  parameter int                 THRESH   = 3,
  parameter int                 CNT_W    = 8,
  parameter int                 HOLD     = 4,
  parameter int                 HOLD_W   = 8,
  parameter logic [W-1:0]       MASK     = 8'h0F
) (
  input  logic              CK,
  input  logic              RN,
  input  logic              en,
  input  logic              clr,
  input  logic [1:0]        mode,
  input  logic [TRIG_W-1:0] trig_in,
  input  logic [W-1:0]      net_in,
  output logic [W-1:0]      net_out,
  output logic              fired,
  output logic [CNT_W-1:0]  count
);

  localparam logic [1:0] DISARMED = 2'd0;
  localparam logic [1:0] ARMED    = 2'd1;
  localparam logic [1:0] ACTIVE   = 2'd2;

  localparam logic [CNT_W-1:0]  THRESH_C    = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0]  THRESH_M1   = CNT_W'(THRESH - 1);
  localparam logic [HOLD_W-1:0] HOLD_C      = HOLD_W'(HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);
  localparam bit                HOLD_TIMED  = (HOLD != 0);

  // Reject parameter sets that the counters cannot represent.
  generate
    if (THRESH < 1 || THRESH > (2 ** CNT_W) - 1) begin : g_bad_thresh
      $error("seq_trojan_net_tap: THRESH out of range for CNT_W");
    end
    if (HOLD < 0 || HOLD > (2 ** HOLD_W) - 1) begin : g_bad_hold
      $error("seq_trojan_net_tap: HOLD out of range for HOLD_W");
    end
  endgenerate

  logic [1:0]        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              match;
  logic              match_d;
  logic              trig_edge;

  assign match     = (trig_in == TRIG_VAL);
  assign trig_edge = match & ~match_d;
  assign fired     = (state == ACTIVE);

  // Trigger edge counting, state sequencing and hold timer.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state    <= DISARMED;
      count    <= '0;
      hold_cnt <= '0;
      match_d  <= 1'b0;
    end else if (clr) begin
      // clr beats any edge or transition in the same cycle.
      state    <= en ? ARMED : DISARMED;
      count    <= '0;
      hold_cnt <= '0;
      match_d  <= 1'b0;
    end else begin
      match_d <= match;
      case (state)
        DISARMED: begin
          count    <= '0;
          hold_cnt <= '0;
          if (en) state <= ARMED;
        end
        ARMED: begin
          if (!en) begin
            state <= DISARMED;
            count <= '0;
          end else if (trig_edge) begin
            if (count == THRESH_M1) begin
              count    <= THRESH_C;
              hold_cnt <= HOLD_C;
              state    <= ACTIVE;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        ACTIVE: begin
          // Disabling wins over expiry; latched mode only leaves on en/clr/reset.
          if (!en) begin
            state    <= DISARMED;
            count    <= '0;
            hold_cnt <= '0;
          end else if (HOLD_TIMED) begin
            if (hold_cnt == HOLD_ONE) begin
              state    <= ARMED;
              count    <= '0;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt - 1'b1;
            end
          end
        end
        default: begin
          state    <= DISARMED;
          count    <= '0;
          hold_cnt <= '0;
        end
      endcase
    end
  end

  // Payload is purely combinational so net_in and mode changes show at once.
  always_comb begin
    net_out = net_in;
    if (fired) begin
      for (int i = 0; i < W; i++) begin
        if (MASK[i]) begin
          case (mode)
            2'd0:    net_out[i] = ~net_in[i];
            2'd1:    net_out[i] = 1'b1;
            2'd2:    net_out[i] = 1'b0;
            default: net_out[i] = net_in[i];
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_trojan_net_tap.sv
// Bench for seq_trojan_net_tap: a timed instance (HOLD=4) and a latched
// instance (HOLD=0) driven by directed vectors, checked through a scoreboard.
module tb_seq_trojan_net_tap;

  logic       CK;
  logic       RN;
  logic [1:0] mode;
  logic [7:0] net_in;

  logic       en_a, clr_a, en_b, clr_b;
  logic [3:0] trig_a, trig_b;
  logic [7:0] out_a, out_b, count_a, count_b;
  logic       fired_a, fired_b;

  typedef struct {
    bit         sel;
    logic [7:0] net;
    logic       fired;
    logic [7:0] cnt;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  seq_trojan_net_tap #(.HOLD(4)) dut_a (
    .CK(CK), .RN(RN), .en(en_a), .clr(clr_a), .mode(mode),
    .trig_in(trig_a), .net_in(net_in), .net_out(out_a),
    .fired(fired_a), .count(count_a)
  );

  seq_trojan_net_tap #(.HOLD(0)) dut_b (
    .CK(CK), .RN(RN), .en(en_b), .clr(clr_b), .mode(mode),
    .trig_in(trig_b), .net_in(net_in), .net_out(out_b),
    .fired(fired_b), .count(count_b)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // Monitor: outputs are settled at the falling edge; drain all pending entries.
  initial begin
    exp_t e;
    forever begin
      @(negedge CK);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.sel) begin
          cmp({e.name, "_net"},   out_b,           e.net);
          cmp({e.name, "_fired"}, {7'd0, fired_b}, {7'd0, e.fired});
          cmp({e.name, "_count"}, count_b,         e.cnt);
        end else begin
          cmp({e.name, "_net"},   out_a,           e.net);
          cmp({e.name, "_fired"}, {7'd0, fired_a}, {7'd0, e.fired});
          cmp({e.name, "_count"}, count_a,         e.cnt);
        end
      end
    end
  end

  task automatic expect_out(input bit sel, input logic [7:0] net, input logic f,
                            input logic [7:0] c, input string nm);
    exp_t e;
    e.sel = sel; e.net = net; e.fired = f; e.cnt = c; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  // Three isolated one-cycle trigger pulses; returns just after the firing edge.
  task automatic fire_a();
    trig_a = 4'hA; step(); trig_a = 4'h0; step();
    trig_a = 4'hA; step(); trig_a = 4'h0; step();
    trig_a = 4'hA; step(); trig_a = 4'h0;
  endtask

  task automatic fire_b();
    trig_b = 4'hA; step(); trig_b = 4'h0; step();
    trig_b = 4'hA; step(); trig_b = 4'h0; step();
    trig_b = 4'hA; step(); trig_b = 4'h0;
  endtask

  initial begin
    RN = 1'b0; mode = 2'd0; net_in = 8'h55;
    en_a = 1'b0; clr_a = 1'b0; trig_a = 4'h0;
    en_b = 1'b0; clr_b = 1'b0; trig_b = 4'h0;

    step();
    expect_out(0, 8'h55, 1'b0, 8'd0, "reset_a");
    expect_out(1, 8'h55, 1'b0, 8'd0, "reset_b");
    step();
    RN = 1'b1; en_a = 1'b1; en_b = 1'b1;
    step();

    // Sustained match counts once.
    trig_a = 4'hA;
    for (int i = 0; i < 10; i++) begin
      step();
      expect_out(0, 8'h55, 1'b0, 8'd1, "sustain");
    end
    trig_a = 4'h0; clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    expect_out(0, 8'h55, 1'b0, 8'd0, "clr_a");

    // Fire and expire after exactly four cycles.
    fire_a();
    expect_out(0, 8'h5A, 1'b1, 8'd3, "fire");
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out(0, 8'h5A, 1'b1, 8'd3, "hold");
    end
    step();
    expect_out(0, 8'h55, 1'b0, 8'd0, "expire");

    // Payload modes take effect combinationally while ACTIVE.
    fire_a();
    mode = 2'd1;
    expect_out(0, 8'h5F, 1'b1, 8'd3, "mode1");
    step(); mode = 2'd2;
    expect_out(0, 8'h50, 1'b1, 8'd3, "mode2");
    step(); mode = 2'd3;
    expect_out(0, 8'h55, 1'b1, 8'd3, "mode3");
    step(); mode = 2'd0;
    expect_out(0, 8'h5A, 1'b1, 8'd3, "mode0");
    step();
    expect_out(0, 8'h55, 1'b0, 8'd0, "mode_expire");

    // Enable drop while ACTIVE, then pulses while disarmed.
    fire_a();
    expect_out(0, 8'h5A, 1'b1, 8'd3, "fire_en");
    en_a = 1'b0;
    step();
    expect_out(0, 8'h55, 1'b0, 8'd0, "en_drop");
    trig_a = 4'hA; step();
    expect_out(0, 8'h55, 1'b0, 8'd0, "dis_pulse1");
    trig_a = 4'h0; step();
    trig_a = 4'hA; step();
    expect_out(0, 8'h55, 1'b0, 8'd0, "dis_pulse2");
    trig_a = 4'h0; step();
    expect_out(0, 8'h55, 1'b0, 8'd0, "dis_idle");

    // Latched payload (HOLD=0) until clr.
    fire_b();
    expect_out(1, 8'h5A, 1'b1, 8'd3, "latch_fire");
    for (int i = 0; i < 20; i++) begin
      step();
      expect_out(1, 8'h5A, 1'b1, 8'd3, "latch_hold");
    end
    clr_b = 1'b1;
    step();
    clr_b = 1'b0;
    expect_out(1, 8'h55, 1'b0, 8'd0, "latch_clr");

    // clr on the same edge as the THRESH-reaching trigger edge.
    trig_b = 4'hA; step(); trig_b = 4'h0; step();
    trig_b = 4'hA; step(); trig_b = 4'h0; step();
    expect_out(1, 8'h55, 1'b0, 8'd2, "pre_race");
    trig_b = 4'hA; clr_b = 1'b1;
    step();
    trig_b = 4'h0; clr_b = 1'b0;
    expect_out(1, 8'h55, 1'b0, 8'd0, "clr_race");
    step();
    expect_out(1, 8'h55, 1'b0, 8'd0, "clr_race_after");

    // Asynchronous reset mid-payload, checked before any further clock edge.
    en_a = 1'b1;
    step();
    fire_a();
    expect_out(0, 8'h5A, 1'b1, 8'd3, "pre_reset");
    step();
    RN = 1'b0;
    expect_out(0, 8'h55, 1'b0, 8'd0, "async_reset");
    step();
    step();

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain actual=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
